data_cache_2way: RTL and testbench
==================================

# data_cache_2way

Two-way set-associative, write-through, no-write-allocate data cache for the RISC-V core's memory stage, the parametrised successor of the direct-mapped spatial-locality RAM cache. It sits between the load/store unit and a word-wide, handshaked main-memory port. It replaces the zero-latency combinational RAM model with a stall-based request interface and a multi-cycle block refill engine. The block also adds LRU replacement and correct byte/half-word merging on store hits.

## Interface
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; fixed at 32 for byte-lane logic.
- SET_BITS, 4, log2 of set count.
- BLOCK_BITS, 2, log2 of words per line. Tag is addr[ADDR_WIDTH-1 : SET_BITS+BLOCK_BITS+2].
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  access request.
- req_ready  out  1  high only in IDLE; an access is accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_type  in  2  00 = word, 01 = byte, 10 = half; 11 is treated as word.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- rd_valid  out  1  one-cycle pulse with load data.
- rd_data  out  DATA_WIDTH  load data, zero-extended for byte and half.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write.
- mem_type  out  2  copy of req_type for writes; 00 for refills.
- mem_addr  out  ADDR_WIDTH  byte address.
- mem_wdata  out  DATA_WIDTH  store data.
- mem_ack  in  1  completes the current transfer; valid in the same cycle as mem_req.
- mem_rdata  in  DATA_WIDTH  refill word, valid with mem_ack.

## Operation
- Storage:
  - Per set, per way: valid bit, tag, and a line of 2^BLOCK_BITS words.
  - Per set: one LRU bit, which names the least recently used way.
- Lookup is combinational on req_addr in IDLE. A hit requires a valid way whose tag matches.
- States: IDLE, REFILL, RESPOND, WRITE.
- IDLE, load hit:
  - Select the word at addr[BLOCK_BITS+1:2].
  - Extract the byte lane from addr[1:0]; extract the half from addr[1], ignoring addr[0].
  - Register the result to rd_data, pulse rd_valid on the next cycle, and set LRU to the other way. Remain in IDLE.
- IDLE, load miss: latch the request; clear word counter cnt; go to REFILL.
- REFILL:
  - Drive mem_req=1, mem_we=0, mem_addr = {line base, cnt, 2'b00}.
  - On each mem_ack, store mem_rdata into the line buffer at cnt and increment cnt.
  - After the ack for the last word, go to RESPOND.
- RESPOND:
  - Victim is the first invalid way (way 0 has priority); otherwise the LRU way.
  - Write buffer, tag and valid=1 into the victim. Set LRU to the other way.
  - Drive rd_valid=1 with the formatted requested word. Return to IDLE.
- IDLE, store: latch the request and go to WRITE.
- WRITE:
  - Drive mem_req=1, mem_we=1, mem_addr=req_addr, mem_wdata, mem_type.
  - On mem_ack:
    - On a hit, merge only the addressed bytes into the cached word, leaving the other bytes intact, and update LRU.
    - On a miss, leave the cache unchanged.
  - Return to IDLE.
- Hit/miss status for the store is the one evaluated at acceptance. No intervening access can invalidate it, because the cache is blocking.

## Timing
- Reset:
  - state = IDLE; req_ready = 1.
  - rd_valid, mem_req and mem_we = 0; rd_data, mem_addr and mem_wdata = 0.
  - All valid and LRU bits cleared. Data and tag arrays are not cleared.
- Load hit: rd_valid one cycle after acceptance.
- Load miss with ack every cycle: rd_valid 2^BLOCK_BITS + 1 cycles after acceptance (5 for defaults). Each stall cycle on mem_ack adds one cycle.
- Store: completes on the mem_ack cycle; req_ready is high the following cycle.
- rst during REFILL or WRITE:
  - mem_req drops the next cycle.
  - No line is installed and no partial state survives.
- req_valid while req_ready = 0 is ignored; the requester holds it.

## Configuration
- CACHE_STATS_EN defined:
  - Adds output ports hit_count and miss_count, each 32 bits and saturating at 0xFFFFFFFF, both cleared by rst.
  - Each accepted load or store increments exactly one counter.
- Not defined: the ports and counters are absent, and the behaviour is otherwise identical.

## Test plan
- Reset, then load word 0x10000004 with 4 acked refill words 0xA0..0xA3 -> mem_addr steps 0x10000000/04/08/0C; rd_data = 0xA1 at cycle 5.
- Repeat the same load, then load 0x1000000C -> both hit, 1-cycle latency, no mem_req; rd_data 0xA1 then 0xA3.
- Three loads to set 0 with tags T1, T2, T1, then a load with tag T3 -> T2's way is evicted; a reload of T1 hits.
- Byte store 0x5A to 0x10000005 (cached word 0x11223344) -> mem write with type 01; a subsequent word load returns 0x11225A44.
- Store miss to an uncached line -> mem write issued; the following load of that address misses and refills.
- Assert rst mid-REFILL after 2 acks -> mem_req low next cycle; a reload of the same address misses again and issues 4 fetches.

Source files
------------

// File: rtl/data_cache_2way.sv
// data_cache_2way: two-way set-associative, write-through, no-write-allocate
// data cache with a blocking request port and a word-serial refill engine.
// Optional feature macro: CACHE_STATS_EN adds saturating hit/miss counters.
module data_cache_2way #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SET_BITS   = 4,
  parameter int BLOCK_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_type,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [1:0]            mem_type,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int WORDS = 1 << BLOCK_BITS;
  localparam int OFF   = BLOCK_BITS + 2;
  localparam int TAG_W = ADDR_WIDTH - SET_BITS - OFF;

  typedef enum logic [1:0] {IDLE, REFILL, RESPOND, WRITE} state_t;

  state_t                state, state_nxt;

  logic [1:0]            valid_q [SETS];
  logic [SETS-1:0]       lru_q;
  logic [TAG_W-1:0]      tag_q   [2][SETS];
  logic [DATA_WIDTH-1:0] data_q  [2][SETS][WORDS];
  logic [DATA_WIDTH-1:0] line_buf [WORDS];
  logic [BLOCK_BITS-1:0] cnt;

  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [1:0]            lat_type;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  lat_hit;
  logic                  lat_way;

  logic                  rd_valid_p1;
  logic [DATA_WIDTH-1:0] rd_data_p1;

  // Zero-extended byte/half extraction; the half lane ignores addr[0].
  function automatic logic [DATA_WIDTH-1:0] fmt_load(input logic [DATA_WIDTH-1:0] w,
                                                     input logic [1:0] t, input logic [1:0] off);
    logic [DATA_WIDTH-1:0] r;
    case (t)
      2'b01:   r = {{(DATA_WIDTH-8){1'b0}}, w[{off, 3'b000} +: 8]};
      2'b10:   r = {{(DATA_WIDTH-16){1'b0}}, w[{off[1], 4'b0000} +: 16]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed byte lanes of a cached word with store data.
  function automatic logic [DATA_WIDTH-1:0] merge_store(input logic [DATA_WIDTH-1:0] w,
                                                        input logic [DATA_WIDTH-1:0] d,
                                                        input logic [1:0] t, input logic [1:0] off);
    logic [DATA_WIDTH-1:0] r;
    r = w;
    case (t)
      2'b01:   r[{off, 3'b000} +: 8]     = d[7:0];
      2'b10:   r[{off[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  logic [SET_BITS-1:0]   req_set, lat_set;
  logic [TAG_W-1:0]      req_tag, lat_tag;
  logic [BLOCK_BITS-1:0] req_word, lat_word;
  logic                  hit0, hit1, hit, hit_way, accept, load_hit, vict;
  logic [DATA_WIDTH-1:0] hit_word, resp_data;

  assign req_set   = req_addr[OFF+SET_BITS-1:OFF];
  assign req_tag   = req_addr[ADDR_WIDTH-1:OFF+SET_BITS];
  assign req_word  = req_addr[OFF-1:2];
  assign lat_set   = lat_addr[OFF+SET_BITS-1:OFF];
  assign lat_tag   = lat_addr[ADDR_WIDTH-1:OFF+SET_BITS];
  assign lat_word  = lat_addr[OFF-1:2];

  assign hit0      = valid_q[req_set][0] && (tag_q[0][req_set] == req_tag);
  assign hit1      = valid_q[req_set][1] && (tag_q[1][req_set] == req_tag);
  assign hit       = hit0 | hit1;
  assign hit_way   = hit1;
  assign hit_word  = hit1 ? data_q[1][req_set][req_word] : data_q[0][req_set][req_word];

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign load_hit  = accept && !req_we && hit;

  // Fill invalid ways first (way 0 before way 1), then evict the LRU way.
  assign vict      = !valid_q[lat_set][0] ? 1'b0 :
                     !valid_q[lat_set][1] ? 1'b1 : lru_q[lat_set];

  assign resp_data = fmt_load(line_buf[lat_word], lat_type, lat_addr[1:0]);
  assign rd_valid  = rd_valid_p1 | (state == RESPOND);
  assign rd_data   = (state == RESPOND) ? resp_data : rd_data_p1;

  // Next-state logic and memory-port drive.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_type  = 2'b00;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = req_we ? WRITE : (hit ? IDLE : REFILL);
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {lat_addr[ADDR_WIDTH-1:OFF], cnt, 2'b00};
        if (mem_ack && (&cnt)) state_nxt = RESPOND;
      end
      RESPOND: state_nxt = IDLE;
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        mem_type  = lat_type;
        if (mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, valid/LRU bits, refill counter and the load response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lru_q       <= '0;
      rd_valid_p1 <= 1'b0;
      rd_data_p1  <= '0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= 2'b00;
    end else begin
      state       <= state_nxt;
      rd_valid_p1 <= load_hit;
      if (load_hit) begin
        rd_data_p1     <= fmt_load(hit_word, req_type, req_addr[1:0]);
        lru_q[req_set] <= ~hit_way;
      end
      if (accept && !req_we && !hit) cnt <= '0;
      if (state == REFILL && mem_ack) cnt <= cnt + 1'b1;
      if (state == RESPOND) begin
        valid_q[lat_set][vict] <= 1'b1;
        lru_q[lat_set]         <= ~vict;
        rd_data_p1             <= resp_data;
      end
      if (state == WRITE && mem_ack && lat_hit) lru_q[lat_set] <= ~lat_way;
    end
  end

  // Datapath storage: request latch, refill buffer, tag/data arrays (never reset).
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_addr  <= req_addr;
      lat_type  <= req_type;
      lat_wdata <= req_wdata;
      lat_hit   <= hit;
      lat_way   <= hit_way;
    end
    if (state == REFILL && mem_ack) line_buf[cnt] <= mem_rdata;
    if (state == RESPOND) begin
      tag_q[vict][lat_set] <= lat_tag;
      for (int w = 0; w < WORDS; w++) data_q[vict][lat_set][w] <= line_buf[w];
    end
    if (state == WRITE && mem_ack && lat_hit)
      data_q[lat_way][lat_set][lat_word] <=
        merge_store(data_q[lat_way][lat_set][lat_word], lat_wdata, lat_type, lat_addr[1:0]);
  end

`ifdef CACHE_STATS_EN
  // Saturating hit/miss counters, one increment per accepted access.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept) begin
      if (hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 1'b1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_cache_2way.sv
// Testbench for data_cache_2way: directed scenarios followed by random traffic,
// checked against a recency-list cache model and a word-addressed memory image.
module tb_data_cache_2way;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_type = 2'b00;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rd_valid, mem_req, mem_we;
  logic [1:0]  mem_type;
  logic [31:0] rd_data, mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  data_cache_2way dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_type(mem_type),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail = 0;
  int          ack_limit = 32'h7FFF_FFFF;
  bit          stall_en = 1'b0;

  logic [31:0] mem_img [logic [31:0]];
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic        log_we[$];
  logic [1:0]  log_type[$];

  // Cache model: per set, up to two tags ordered most-recent first.
  logic [23:0] mdl_tag [16][2];
  int          mdl_n [16];

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    if (mem_img.exists(wa)) return mem_img[wa];
    return (wa * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int s;
    s = int'(a[7:4]);
    for (int i = 0; i < mdl_n[s]; i++) if (mdl_tag[s][i] == a[31:8]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_touch(input logic [31:0] a);
    int s;
    logic [23:0] t;
    s = int'(a[7:4]);
    t = a[31:8];
    if (mdl_n[s] >= 1 && mdl_tag[s][0] == t) return;
    if (mdl_n[s] == 2 && mdl_tag[s][1] == t) begin
      mdl_tag[s][1] = mdl_tag[s][0];
      mdl_tag[s][0] = t;
      return;
    end
    mdl_tag[s][1] = mdl_tag[s][0];
    mdl_tag[s][0] = t;
    if (mdl_n[s] < 2) mdl_n[s]++;
  endfunction

  function automatic logic [31:0] ref_fmt(input logic [31:0] w, input logic [1:0] t, input logic [31:0] a);
    int sh;
    case (t)
      2'b01: begin sh = 8 * int'(a % 4); return (w >> sh) & 32'hFF; end
      2'b10: begin sh = 16 * int'((a / 2) % 2); return (w >> sh) & 32'hFFFF; end
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] d,
                                            input logic [1:0] t, input logic [31:0] a);
    int sh;
    logic [31:0] mask;
    case (t)
      2'b01: begin sh = 8 * int'(a % 4); mask = 32'hFF << sh;
                   return (old & ~mask) | ((d & 32'hFF) << sh); end
      2'b10: begin sh = 16 * int'((a / 2) % 2); mask = 32'hFFFF << sh;
                   return (old & ~mask) | ((d & 32'hFFFF) << sh); end
      default: return d;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: acks (optionally with random stalls) and logs each transfer.
  always @(negedge clk) begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    if (mem_req && !rst && log_addr.size() < ack_limit &&
        (!stall_en || $urandom_range(0, 2) != 0)) begin
      mem_ack = 1'b1;
      if (!mem_we) mem_rdata = mem_word(mem_addr);
      log_addr.push_back(mem_addr);
      log_we.push_back(mem_we);
      log_type.push_back(mem_type);
      log_wdata.push_back(mem_wdata);
    end
  end

  task automatic issue(input logic we, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("issue_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_type  = t;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] t, input int want_hit);
    int base, n, exp_hit;
    logic [31:0] exp_d, line;
    base    = log_addr.size();
    exp_hit = (want_hit >= 0) ? want_hit : int'(model_hit(a));
    exp_d   = ref_fmt(mem_word({a[31:2], 2'b00}), t, a);
    line    = {a[31:4], 4'b0000};
    issue(1'b0, t, a, $urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_valid && n < 200);
    chk("load_rd_valid", 32'(rd_valid), 32'd1);
    chk("load_rd_data", rd_data, exp_d);
    chk("load_fetch_count", 32'(log_addr.size() - base), (exp_hit != 0) ? 32'd0 : 32'd4);
    if (!stall_en) chk("load_latency", 32'(n), (exp_hit != 0) ? 32'd1 : 32'd5);
    if (exp_hit == 0 && log_addr.size() - base == 4)
      for (int i = 0; i < 4; i++) begin
        chk("refill_addr", log_addr[base+i], line + 32'(4 * i));
        chk("refill_we", 32'(log_we[base+i]), 32'd0);
        chk("refill_type", 32'(log_type[base+i]), 32'd0);
      end
    model_touch(a);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] t, input logic [31:0] d);
    int base, n;
    bit h;
    logic [31:0] wa;
    base = log_addr.size();
    h    = model_hit(a);
    wa   = {a[31:2], 2'b00};
    issue(1'b1, t, a, d);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 200);
    chk("store_done", 32'(req_ready), 32'd1);
    chk("store_write_count", 32'(log_addr.size() - base), 32'd1);
    if (log_addr.size() > base) begin
      chk("store_addr", log_addr[base], a);
      chk("store_we", 32'(log_we[base]), 32'd1);
      chk("store_type", 32'(log_type[base]), 32'(t));
      chk("store_wdata", log_wdata[base], d);
    end
    if (!stall_en) chk("store_latency", 32'(n), 32'd2);
    mem_img[wa] = ref_merge(mem_word(wa), d, t, a);
    if (h) model_touch(a);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "timeout");
  end

  initial begin
    int base, n;
    logic [23:0] pool [4];
    logic [31:0] a;
    pool = '{24'h100000, 24'h100001, 24'h200000, 24'h300000};
    for (int s = 0; s < 16; s++) mdl_n[s] = 0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);

    mem_img[32'h1000_0000] = 32'hA0;
    mem_img[32'h1000_0004] = 32'hA1;
    mem_img[32'h1000_0008] = 32'hA2;
    mem_img[32'h1000_000C] = 32'hA3;
    do_load(32'h1000_0004, 2'b00, 0);
    chk("first_load_data", rd_data, 32'hA1);
    do_load(32'h1000_0004, 2'b00, 1);
    chk("repeat_load_data", rd_data, 32'hA1);
    do_load(32'h1000_000C, 2'b00, 1);
    chk("same_line_load_data", rd_data, 32'hA3);

    do_load(32'h2000_0000, 2'b00, 0);
    do_load(32'h1000_0000, 2'b00, 1);
    do_load(32'h3000_0000, 2'b00, 0);
    do_load(32'h1000_0000, 2'b00, 1);
    do_load(32'h2000_0000, 2'b00, 0);

    do_store(32'h1000_0004, 2'b00, 32'h1122_3344);
    do_store(32'h1000_0005, 2'b01, 32'h0000_005A);
    do_load(32'h1000_0004, 2'b00, 1);
    chk("byte_merge_word", rd_data, 32'h1122_5A44);
    do_load(32'h1000_0005, 2'b01, 1);
    chk("byte_load", rd_data, 32'h0000_005A);
    do_load(32'h1000_0007, 2'b10, 1);
    chk("half_load", rd_data, 32'h0000_1122);

    do_store(32'h4000_0010, 2'b00, 32'hCAFE_F00D);
    do_load(32'h4000_0010, 2'b00, 0);
    chk("store_miss_reload", rd_data, 32'hCAFE_F00D);

    base = log_addr.size();
    ack_limit = base + 2;
    issue(1'b0, 2'b00, 32'h5000_0020, 32'h0);
    n = 0;
    while (log_addr.size() - base < 2 && n < 50) begin @(negedge clk); n++; end
    chk("rst_refill_two_acks", 32'(log_addr.size() - base), 32'd2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mem_req_before", 32'(mem_req), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_req_drop", 32'(mem_req), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    for (int s = 0; s < 16; s++) mdl_n[s] = 0;
    ack_limit = 32'h7FFF_FFFF;
    do_load(32'h5000_0020, 2'b00, 0);
    do_load(32'h1000_0004, 2'b00, 0);

    stall_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = {pool[$urandom_range(0, 3)], 4'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 2) == 0) do_store(a, 2'($urandom_range(0, 3)), $urandom);
      else                           do_load(a, 2'($urandom_range(0, 3)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
